// File: rtl/pix_stream_tx.sv
// Pixel-stream transmitter: unpacks multi-pixel words into one pixel per cycle on a
// valid/ready stream and tags each pixel with raster position flags (sof/eol/eof).
module pix_stream_tx #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_WORD = 4,
  parameter int IMG_WIDTH       = 854,
  parameter int IMG_HEIGHT      = 480
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] w_data,
  output logic                                   p_valid,
  input  logic                                   p_ready,
  output logic [PIXEL_WIDTH-1:0]                 pixel,
  output logic                                   p_sof,
  output logic                                   p_eol,
  output logic                                   p_eof,
  output logic                                   frame_done
);

  localparam int LW = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] SEND  = 1'b1;

  logic [0:0]                                  state;
  logic [PIXELS_PER_WORD-1:0][PIXEL_WIDTH-1:0] word;
  logic [LW-1:0]                               lane;
  logic [CW-1:0]                               col;
  logic [RW-1:0]                               row;

  logic col_last, row_last, lane_last, px_hs, take_word, w_hs;

  assign p_valid  = (state == SEND);
  assign pixel    = word[lane];
  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));

  assign p_sof = p_valid && (row == '0) && (col == '0);
  assign p_eol = p_valid && col_last;
  assign p_eof = p_eol && row_last;

  // The eof pixel ends the word early so the next frame starts on a fresh lane 0.
  assign lane_last = (lane == LW'(PIXELS_PER_WORD - 1)) || (col_last && row_last);
  assign px_hs     = p_valid && p_ready;
  assign take_word = (state == EMPTY) || (px_hs && lane_last);
  assign w_ready   = rst && take_word;
  assign w_hs      = w_valid && take_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      word       <= '0;
      lane       <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= px_hs && p_eof;
      if (px_hs) begin
        lane <= lane_last ? '0 : lane + LW'(1);
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (w_hs) begin
        word  <= w_data;
        lane  <= '0;
        state <= SEND;
      end else if (px_hs && lane_last) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_pix_stream_tx.sv
// Directed bench: A is a 6x2 frame (3 whole words), B is a 5x1 frame (partial eof word).
module tb_pix_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [31:0] w_data = '0;

  logic       a_wr, a_pv, a_sof, a_eol, a_eof, a_fd;
  logic [7:0] a_px;
  logic       b_wr, b_pv, b_sof, b_eol, b_eof, b_fd;
  logic [7:0] b_px;

  always #5 clk = ~clk;

  pix_stream_tx #(.PIXEL_WIDTH(8), .PIXELS_PER_WORD(4), .IMG_WIDTH(6), .IMG_HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(a_wr), .w_data(w_data),
    .p_valid(a_pv), .p_ready(p_ready), .pixel(a_px), .p_sof(a_sof), .p_eol(a_eol),
    .p_eof(a_eof), .frame_done(a_fd));

  pix_stream_tx #(.PIXEL_WIDTH(8), .PIXELS_PER_WORD(4), .IMG_WIDTH(5), .IMG_HEIGHT(1)) dut_b (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(b_wr), .w_data(w_data),
    .p_valid(b_pv), .p_ready(p_ready), .pixel(b_px), .p_sof(b_sof), .p_eol(b_eol),
    .p_eof(b_eof), .frame_done(b_fd));

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        pr;
    logic        pv;
    logic [7:0]  px;
    logic        sof, eol, eof, wr, fd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic pr,
                              input logic pv, input logic [7:0] px, input logic sof,
                              input logic eol, input logic eof, input logic wr, input logic fd);
    vec_t v;
    v.wv = wv; v.wd = wd; v.pr = pr; v.pv = pv; v.px = px;
    v.sof = sof; v.eol = eol; v.eof = eof; v.wr = wr; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare settled outputs before the rising edge.
  task automatic apply(input vec_t v, input bit sel_b, input int idx);
    logic       pv, sof, eol, eof, wr, fd;
    logic [7:0] px;
    @(negedge clk);
    w_valid = v.wv; w_data = v.wd; p_ready = v.pr;
    #1;
    pv  = sel_b ? b_pv  : a_pv;  px  = sel_b ? b_px  : a_px;
    sof = sel_b ? b_sof : a_sof; eol = sel_b ? b_eol : a_eol;
    eof = sel_b ? b_eof : a_eof; wr  = sel_b ? b_wr  : a_wr;
    fd  = sel_b ? b_fd  : a_fd;
    chk("p_valid", idx, 32'(pv), 32'(v.pv));
    if (v.pv) chk("pixel", idx, 32'(px), 32'(v.px));
    chk("p_sof", idx, 32'(sof), 32'(v.sof));
    chk("p_eol", idx, 32'(eol), 32'(v.eol));
    chk("p_eof", idx, 32'(eof), 32'(v.eof));
    chk("w_ready", idx, 32'(wr), 32'(v.wr));
    chk("frame_done", idx, 32'(fd), 32'(v.fd));
  endtask

  vec_t va[21];
  vec_t vb[8];

  initial begin
    //           wv  w_data        pr  pv  px     sof eol eof wr fd
    va[0]  = mk(1, 32'h44332211, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    va[1]  = mk(1, 32'h88776655, 1, 1, 8'h11, 1, 0, 0, 0, 0);
    va[2]  = mk(1, 32'h88776655, 0, 1, 8'h22, 0, 0, 0, 0, 0);
    va[3]  = mk(1, 32'h88776655, 0, 1, 8'h22, 0, 0, 0, 0, 0);
    va[4]  = mk(1, 32'h88776655, 0, 1, 8'h22, 0, 0, 0, 0, 0);
    va[5]  = mk(1, 32'h88776655, 1, 1, 8'h22, 0, 0, 0, 0, 0);
    va[6]  = mk(1, 32'h88776655, 1, 1, 8'h33, 0, 0, 0, 0, 0);
    va[7]  = mk(1, 32'h88776655, 1, 1, 8'h44, 0, 0, 0, 1, 0);
    va[8]  = mk(1, 32'hccbbaa99, 1, 1, 8'h55, 0, 0, 0, 0, 0);
    va[9]  = mk(1, 32'hccbbaa99, 1, 1, 8'h66, 0, 1, 0, 0, 0);
    va[10] = mk(1, 32'hccbbaa99, 1, 1, 8'h77, 0, 0, 0, 0, 0);
    va[11] = mk(1, 32'hccbbaa99, 1, 1, 8'h88, 0, 0, 0, 1, 0);
    va[12] = mk(0, 32'h0,        1, 1, 8'h99, 0, 0, 0, 0, 0);
    va[13] = mk(0, 32'h0,        1, 1, 8'haa, 0, 0, 0, 0, 0);
    va[14] = mk(0, 32'h0,        1, 1, 8'hbb, 0, 0, 0, 0, 0);
    va[15] = mk(0, 32'h0,        1, 1, 8'hcc, 0, 1, 1, 1, 0);
    va[16] = mk(0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 1);
    va[17] = mk(0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 1, 0);
    va[18] = mk(1, 32'hf4f3f2f1, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    va[19] = mk(0, 32'h0,        1, 1, 8'hf1, 1, 0, 0, 0, 0);
    va[20] = mk(0, 32'h0,        1, 1, 8'hf2, 0, 0, 0, 0, 0);

    vb[0]  = mk(1, 32'h04030201, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    vb[1]  = mk(1, 32'h08070605, 1, 1, 8'h01, 1, 0, 0, 0, 0);
    vb[2]  = mk(1, 32'h08070605, 1, 1, 8'h02, 0, 0, 0, 0, 0);
    vb[3]  = mk(1, 32'h08070605, 1, 1, 8'h03, 0, 0, 0, 0, 0);
    vb[4]  = mk(1, 32'h08070605, 1, 1, 8'h04, 0, 0, 0, 1, 0);
    vb[5]  = mk(1, 32'h0c0b0a09, 1, 1, 8'h05, 0, 1, 1, 1, 0);
    vb[6]  = mk(0, 32'h0,        1, 1, 8'h09, 1, 0, 0, 0, 1);
    vb[7]  = mk(0, 32'h0,        1, 1, 8'h0a, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_p_valid", 0, 32'(a_pv), 32'(1'b0));
    chk("rst_w_ready", 0, 32'(a_wr), 32'(1'b0));
    chk("rst_pixel",   0, 32'(a_px), 32'(8'h00));
    chk("rst_p_sof",   0, 32'(a_sof), 32'(1'b0));
    chk("rst_frame_done", 0, 32'(a_fd), 32'(1'b0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) apply(va[i], 1'b0, i);

    // Reset mid-word: pixel f3 held, then rst drops p_valid at once.
    apply(mk(0, 32'h0, 0, 1, 8'hf3, 0, 0, 0, 0, 0), 1'b0, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_p_valid", 101, 32'(a_pv), 32'(1'b0));
    chk("midrst_w_ready", 101, 32'(a_wr), 32'(1'b0));
    chk("midrst_pixel",   101, 32'(a_px), 32'(8'h00));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_w_ready", 102, 32'(a_wr), 32'(1'b1));
    chk("postrst_p_valid", 102, 32'(a_pv), 32'(1'b0));
    apply(mk(1, 32'h0d0c0b0a, 1, 0, 8'h00, 0, 0, 0, 1, 0), 1'b0, 103);
    apply(mk(0, 32'h0,        1, 1, 8'h0a, 1, 0, 0, 0, 0), 1'b0, 104);
    apply(mk(0, 32'h0,        1, 1, 8'h0b, 0, 0, 0, 0, 0), 1'b0, 105);

    // Fresh reset, then the partial-word frame end on the 5x1 instance.
    @(negedge clk);
    w_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) apply(vb[i], 1'b1, 200 + i);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
